// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: MD timer states,
// default MD latencies and the exception vector.
package pipe_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: IDLE/BUSY FSM plus a loadable down-counter that
// holds busy for exactly MULT_CYCLES or DIV_CYCLES cycles after a start.
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic div,
    output logic busy
);

    localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);

    md_state_t     state;
    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            count <= '0;
        end else if (go) begin
            // A start while already busy reloads the count.
            state <= MD_BUSY;
            count <= div ? DIV_LD : MULT_LD;
        end else if (state == MD_BUSY) begin
            if (count <= CW'(1)) begin
                state <= MD_IDLE;
                count <= '0;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Define PIPE_HAZARD_CTRL_PERF_EN to add the stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_rs_rd,
    input  logic        d_rt_rd,
    input  logic        d_rs_early,
    input  logic        d_rt_early,
    input  logic        d_md,
    input  logic [4:0]  e_regaddr,
    input  logic        e_regwrite,
    input  logic        e_memtoreg,
    input  logic [4:0]  m_regaddr,
    input  logic        m_memtoreg,
    input  logic        e_mdstart,
    input  logic        e_mddiv,
    input  logic        req,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        flush,
    output logic        md_go,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        md_busy
);

    logic rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;
    logic load_use, early_use, md_stall, stall;

    // $0 is hardwired to zero and never carries a dependency.
    assign rs_hit_e = (d_rs != 5'd0) && (d_rs == e_regaddr);
    assign rt_hit_e = (d_rt != 5'd0) && (d_rt == e_regaddr);
    assign rs_hit_m = (d_rs != 5'd0) && (d_rs == m_regaddr);
    assign rt_hit_m = (d_rt != 5'd0) && (d_rt == m_regaddr);

    assign load_use  = e_memtoreg & ((rs_hit_e & d_rs_rd) | (rt_hit_e & d_rt_rd));
    assign early_use = (d_rs_early & ((rs_hit_e & e_regwrite) | (rs_hit_m & m_memtoreg)))
                     | (d_rt_early & ((rt_hit_e & e_regwrite) | (rt_hit_m & m_memtoreg)));
    assign md_stall  = d_md & (md_busy | e_mdstart);
    assign stall     = load_use | early_use | md_stall;

    // A start coincident with req belongs to an instruction being flushed.
    assign md_go = e_mdstart & ~req & ~reset;

    // NOTE: every output gets a default before the priority chain, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        pc_en  = 1'b0;
        fd_en  = 1'b0;
        de_clr = 1'b0;
        flush  = 1'b0;
        if (reset) begin
            // Pipeline registers run their own reset; hold everything low.
        end else if (req) begin
            flush = 1'b1;
            pc_en = 1'b1;
            fd_en = 1'b1;
        end else if (stall) begin
            de_clr = 1'b1;
        end else begin
            pc_en = 1'b1;
            fd_en = 1'b1;
        end
    end

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk   (clk),
        .reset (reset),
        .go    (md_go),
        .div   (e_mddiv),
        .busy  (md_busy)
    );

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall & ~req) stall_cnt <= stall_cnt + 32'd1;
            if (req)          flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. Decides every cycle whether the PC and F/D register advance, whether the D/E register loads a bubble, and whether the whole pipeline flushes to the exception vector. Owns the multiply/divide busy timer, so D-stage HI/LO instructions wait for an in-flight mult/div. Sits beside the pipeline registers; its outputs drive their enable, `stall`, `clr` and `req` inputs.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- d_rs, d_rt  in  5 each  D-stage source register numbers
- d_rs_rd, d_rt_rd  in  1 each  D instruction reads rs / rt
- d_rs_early, d_rt_early  in  1 each  operand needed in D (branch compare, jr/jalr)
- d_md  in  1  D instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo)
- e_regaddr  in  5  E-stage destination
- e_regwrite, e_memtoreg  in  1 each  E writes a register / E is a load
- m_regaddr  in  5  M-stage destination
- m_memtoreg  in  1  M is a load
- e_mdstart  in  1  E instruction starts the MD unit
- e_mddiv  in  1  the start is div/divu (else mult/multu)
- req  in  1  exception or interrupt taken at M this cycle
- pc_en  out  1  PC loads its next value
- fd_en  out  1  F/D register loads
- de_clr  out  1  D/E inserts a bubble; pc and BD are kept (drives D/E `reset` and `clr` together)
- flush  out  1  all pipeline registers reset toward 0x4180
- md_go  out  1  qualified MD start to the mult/div unit
- md_busy  out  1  MD unit busy

## Operation
- Register 0 never causes a hazard; a match needs a nonzero, equal address.
- load_use = e_memtoreg & (rs match E & d_rs_rd | rt match E & d_rt_rd).
- early_use = (E match with e_regwrite) or (M match with m_memtoreg), applied to rs when d_rs_early and to rt when d_rt_early.
- md_stall = d_md & (md_busy | e_mdstart).
- stall = load_use | early_use | md_stall.
- Priority: reset > req > stall > run.
  - req: flush=1, pc_en=1, fd_en=1, de_clr=0.
  - stall: pc_en=0, fd_en=0, de_clr=1.
  - run: pc_en=1, fd_en=1, others 0.
- md_go = e_mdstart & ~req. The starting instruction is flushed with the pipeline, so a start coincident with req never begins.
- MD timer, states IDLE and BUSY:
  - IDLE→BUSY on md_go; count loads DIV_CYCLES if e_mddiv, else MULT_CYCLES.
  - In BUSY the count decrements each cycle; BUSY→IDLE when count reaches 1, with count going to 0.
  - md_busy = (state==BUSY).
  - req does not abort a started operation; BUSY continues to completion.
  - md_go while BUSY cannot occur, because md_stall holds the issuing instruction in D; if it does occur anyway, the count reloads.
- Count width is $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

## Timing
- Hazard outputs are combinational from the inputs in the same cycle; the MD timer is registered.
- md_go in cycle T → md_busy high in cycles T+1 … T+N, low at T+N+1.
- Asynchronous reset:
  - Timer goes to IDLE with count 0.
  - While reset is high, all outputs are 0, including pc_en and fd_en; the pipeline registers perform their own reset.
- Reset mid-BUSY drops md_busy immediately.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined adds two 32-bit outputs:
  - stall_cnt increments on each cycle with stall & ~req.
  - flush_cnt increments on each cycle with req.
  - Both wrap at 2^32 and reset to 0.
- Undefined: neither port nor its counter exists.

## Structure
- Shared package `pipe_pkg` holds the MD state enum, MULT_CYCLES/DIV_CYCLES defaults, and the exception vector 32'h4180.
- One sub-module, `md_busy_timer`: loadable down-counter plus the IDLE/BUSY FSM. Hazard comparison stays in the top module.

## Test plan
- E=lw $5, D=addu $6,$5,$1 (d_rs=5, d_rs_rd=1) → pc_en=0, fd_en=0, de_clr=1 for one cycle; next cycle with E bubble → all run.
- E=addu $3 (regwrite), D=beq $3,$0 (d_rs_early=1) → stall; M=lw $3 with D=beq $3 → stall; same case with d_rs=0 → no stall.
- md_go with e_mddiv=1, then D=mflo → md_busy high exactly 10 cycles, D stalled throughout, released the cycle md_busy falls; repeat with mult → 5 cycles.
- e_mdstart=1 and req=1 in the same cycle → md_go=0, flush=1, md_busy stays 0.
- req while load_use is active → flush=1, pc_en=1, de_clr=0.
- reset asserted at the 3rd busy cycle of a div → md_busy=0 and all outputs 0 immediately; after release the timer is in IDLE. With PERF_EN, stall_cnt and flush_cnt read 0.
